// File: rtl/ariane_pkg.sv
// Shared core types: scoreboard sizing, the exception record and the scoreboard entry
// that travels from decode through issue and writeback to commit.
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int unsigned NR_WB_PORTS   = 3;

  typedef enum logic [2:0] {
    FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;

endpackage

// File: rtl/scoreboard.sv
// In-order scoreboard: a circular buffer of in-flight instructions with separate
// dispatch (tail), issue and commit (head) pointers, writeback capture and operand forwarding.
module scoreboard #(
  parameter int unsigned NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic                                                  flush_i,
  input  ariane_pkg::scoreboard_entry_t                         decoded_instr_i,
  input  logic                                                  decoded_instr_valid_i,
  output logic                                                  decoded_instr_ack_o,
  output logic                                                  full_o,
  output ariane_pkg::scoreboard_entry_t                         issue_instr_o,
  output logic                                                  issue_valid_o,
  input  logic                                                  issue_ack_i,
  input  logic [NR_WB_PORTS-1:0][ariane_pkg::TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                          wdata_i,
  input  ariane_pkg::exception_t [NR_WB_PORTS-1:0]              ex_i,
  input  logic [NR_WB_PORTS-1:0]                                wb_valid_i,
  output ariane_pkg::scoreboard_entry_t                         commit_instr_o,
  output logic                                                  commit_valid_o,
  input  logic                                                  commit_ack_i,
  output logic [31:0]                                           rd_busy_o,
  input  logic [4:0]                                            rs1_i,
  input  logic [4:0]                                            rs2_i,
  output logic [63:0]                                           rs1_o,
  output logic [63:0]                                           rs2_o,
  output logic                                                  rs1_valid_o,
  output logic                                                  rs2_valid_o
);

  localparam int unsigned PTR_W = ariane_pkg::TRANS_ID_BITS;
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t                          head_q, issue_q, tail_q;
  logic [PTR_W:0]                count_q;
  logic [NR_ENTRIES-1:0]         occupied_q, valid_q, issued_q;
  ariane_pkg::scoreboard_entry_t mem_q [NR_ENTRIES];

  logic issue_fire, commit_fire, issue_skip;

  assign full_o              = (count_q == (PTR_W+1)'(NR_ENTRIES));
  assign decoded_instr_ack_o = rst_ni && decoded_instr_valid_i && !full_o && !flush_i;
  assign issue_valid_o       = (issue_q != tail_q) ||
                               (full_o && (issue_q == head_q) && !issued_q[head_q]);
  assign commit_valid_o      = (count_q != '0) && valid_q[head_q];
  assign issue_fire          = issue_ack_i && issue_valid_o;
  assign commit_fire         = commit_ack_i && commit_valid_o;
  // Committing an entry that finished before it was issued drags the issue pointer along.
  assign issue_skip          = commit_fire && (issue_q == head_q) && !issued_q[head_q];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    issue_instr_o        = mem_q[issue_q];
    issue_instr_o.valid  = valid_q[issue_q];
    commit_instr_o       = mem_q[head_q];
    commit_instr_o.valid = valid_q[head_q];
    rd_busy_o            = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++)
      if (occupied_q[i]) rd_busy_o[mem_q[i].rd] = 1'b1;
    rd_busy_o[0] = 1'b0;
  end

  // Walk head to tail so the youngest matching producer overrides older ones.
  always_comb begin
    ptr_t idx;
    idx         = '0;
    rs1_o       = '0;
    rs2_o       = '0;
    rs1_valid_o = 1'b0;
    rs2_valid_o = 1'b0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      idx = head_q + ptr_t'(i);
      if (occupied_q[idx] && mem_q[idx].rd == rs1_i) begin
        rs1_o       = mem_q[idx].result;
        rs1_valid_o = valid_q[idx];
      end
      if (occupied_q[idx] && mem_q[idx].rd == rs2_i) begin
        rs2_o       = mem_q[idx].result;
        rs2_valid_o = valid_q[idx];
      end
    end
    if (rs1_i == 5'd0) rs1_valid_o = 1'b0;
    if (rs2_i == 5'd0) rs2_valid_o = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments; later writes in the block win.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      issue_q    <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      occupied_q <= '0;
      valid_q    <= '0;
      issued_q   <= '0;
    end else if (flush_i) begin
      head_q     <= '0;
      issue_q    <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      occupied_q <= '0;
      valid_q    <= '0;
      issued_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < NR_WB_PORTS; k++)
        if (wb_valid_i[k] && occupied_q[trans_id_i[k]]) valid_q[trans_id_i[k]] <= 1'b1;
      if (issue_fire) issued_q[issue_q] <= 1'b1;
      if (issue_fire || issue_skip) issue_q <= issue_q + ptr_t'(1);
      if (commit_fire) begin
        occupied_q[head_q] <= 1'b0;
        valid_q[head_q]    <= 1'b0;
        issued_q[head_q]   <= 1'b0;
        head_q             <= head_q + ptr_t'(1);
      end
      if (decoded_instr_ack_o) begin
        occupied_q[tail_q] <= 1'b1;
        valid_q[tail_q]    <= 1'b0;
        issued_q[tail_q]   <= 1'b0;
        tail_q             <= tail_q + ptr_t'(1);
      end
      case ({decoded_instr_ack_o, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the payload array is not reset; the occupancy and valid flags gate every use of it.
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      if (wb_valid_i[k] && occupied_q[trans_id_i[k]]) begin
        mem_q[trans_id_i[k]].result <= wdata_i[k];
        if (ex_i[k].valid) mem_q[trans_id_i[k]].ex <= ex_i[k];
      end
    end
    if (decoded_instr_ack_o) begin
      mem_q[tail_q]          <= decoded_instr_i;
      mem_q[tail_q].trans_id <= tail_q;
      mem_q[tail_q].valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed scenarios plus a randomized run
// compared against a queue-based model of the in-flight instruction window.
module tb_scoreboard;
  import ariane_pkg::*;

  localparam int N = 4;
  localparam int W = 3;

  logic                          clk_i = 1'b0;
  logic                          rst_ni;
  logic                          flush_i;
  scoreboard_entry_t             decoded_instr_i;
  logic                          decoded_instr_valid_i;
  logic                          decoded_instr_ack_o;
  logic                          full_o;
  scoreboard_entry_t             issue_instr_o;
  logic                          issue_valid_o;
  logic                          issue_ack_i;
  logic [W-1:0][1:0]             trans_id_i;
  logic [W-1:0][63:0]            wdata_i;
  exception_t [W-1:0]            ex_i;
  logic [W-1:0]                  wb_valid_i;
  scoreboard_entry_t             commit_instr_o;
  logic                          commit_valid_o;
  logic                          commit_ack_i;
  logic [31:0]                   rd_busy_o;
  logic [4:0]                    rs1_i, rs2_i;
  logic [63:0]                   rs1_o, rs2_o;
  logic                          rs1_valid_o, rs2_valid_o;

  int checks = 0;
  int errors = 0;

  scoreboard #(.NR_ENTRIES(N), .NR_WB_PORTS(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .decoded_instr_i(decoded_instr_i), .decoded_instr_valid_i(decoded_instr_valid_i),
    .decoded_instr_ack_o(decoded_instr_ack_o), .full_o(full_o),
    .issue_instr_o(issue_instr_o), .issue_valid_o(issue_valid_o), .issue_ack_i(issue_ack_i),
    .trans_id_i(trans_id_i), .wdata_i(wdata_i), .ex_i(ex_i), .wb_valid_i(wb_valid_i),
    .commit_instr_o(commit_instr_o), .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i),
    .rd_busy_o(rd_busy_o), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rs1_valid_o(rs1_valid_o), .rs2_valid_o(rs2_valid_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: program-ordered list of in-flight instructions, oldest first.
  typedef struct {
    logic [1:0]  id;
    logic [4:0]  rd;
    logic [63:0] res;
    bit          done;
    bit          issued;
    bit          exv;
  } ent_t;

  ent_t q[$];
  int   next_id;

  function automatic int first_unissued();
    foreach (q[i]) if (!q[i].issued) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] r = '0;
    foreach (q[i]) r[q[i].rd] = 1'b1;
    r[0] = 1'b0;
    return r;
  endfunction

  task automatic m_fwd(input logic [4:0] rs, output bit v, output logic [63:0] d);
    v = 1'b0;
    d = '0;
    if (rs == 5'd0) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].rd == rs) begin
        v = q[i].done;
        d = q[i].res;
        return;
      end
    end
  endtask

  task automatic model_step();
    bit full, cv;
    int ui;
    if (flush_i) begin
      q.delete();
      next_id = 0;
      return;
    end
    full = (q.size() == N);
    cv   = (q.size() > 0) && q[0].done;
    ui   = first_unissued();
    for (int k = 0; k < W; k++) begin
      if (wb_valid_i[k]) begin
        foreach (q[j]) begin
          if (q[j].id == trans_id_i[k]) begin
            q[j].res  = wdata_i[k];
            q[j].done = 1'b1;
            if (ex_i[k].valid) q[j].exv = 1'b1;
          end
        end
      end
    end
    if (issue_ack_i && ui >= 0) q[ui].issued = 1'b1;
    if (commit_ack_i && cv) void'(q.pop_front());
    if (decoded_instr_valid_i && !full) begin
      ent_t e;
      e.id = 2'(next_id);
      e.rd = decoded_instr_i.rd;
      e.res = '0;
      e.done = 1'b0;
      e.issued = 1'b0;
      e.exv = decoded_instr_i.ex.valid;
      q.push_back(e);
      next_id = (next_id + 1) % N;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 1'b0;
    decoded_instr_valid_i = 1'b0;
    decoded_instr_i = '0;
    issue_ack_i = 1'b0;
    commit_ack_i = 1'b0;
    wb_valid_i = '0;
    trans_id_i = '0;
    wdata_i = '0;
    ex_i = '0;
    rs1_i = '0;
    rs2_i = '0;
  endtask

  task automatic set_instr(input logic [4:0] rd);
    decoded_instr_i = '0;
    decoded_instr_i.pc = {32'h0, $urandom};
    decoded_instr_i.rd = rd;
    decoded_instr_valid_i = 1'b1;
  endtask

  task automatic dispatch_n(input int n, input logic [4:0] rd0);
    for (int i = 0; i < n; i++) begin
      set_instr(rd0 + 5'(i));
      tick();
    end
    decoded_instr_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    decoded_instr_valid_i = 1'b1;
    rs1_i = 5'd5;
    rs2_i = 5'd6;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({full_o, decoded_instr_ack_o, issue_valid_o, commit_valid_o, rs1_valid_o, rs2_valid_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got full/ack/iv/cv/r1v/r2v=%b expected 000000",
               {full_o, decoded_instr_ack_o, issue_valid_o, commit_valid_o, rs1_valid_o, rs2_valid_o});
    end
    checks++;
    if (rd_busy_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy: got %h expected 0", rd_busy_o);
    end
    idle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    q.delete();
    next_id = 0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_latency();
    do_flush();
    checks++;
    if (issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_empty: issue_valid got %b expected 0", issue_valid_o);
    end
    dispatch_n(1, 5'd3);
    checks++;
    if (issue_valid_o !== 1'b1 || issue_instr_o.trans_id !== 2'd0) begin
      errors++;
      $display("FAIL latency_issue: valid=%b id=%0d expected valid=1 id=0", issue_valid_o, issue_instr_o.trans_id);
    end
  endtask

  task automatic test_full();
    do_flush();
    dispatch_n(4, 5'd1);
    checks++;
    if (full_o !== 1'b1) begin
      errors++;
      $display("FAIL full_flag: got %b expected 1", full_o);
    end
    set_instr(5'd9);
    #1;
    checks++;
    if (decoded_instr_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL full_ack: got %b expected 0", decoded_instr_ack_o);
    end
    tick();
    decoded_instr_valid_i = 1'b0;
    checks++;
    if (dut.tail_q !== 2'd0 || dut.count_q !== 3'd4) begin
      errors++;
      $display("FAIL full_tail: tail=%0d count=%0d expected tail=0 count=4", dut.tail_q, dut.count_q);
    end
    checks++;
    if (rd_busy_o !== 32'h1E) begin
      errors++;
      $display("FAIL full_busy: got %h expected 0000001e", rd_busy_o);
    end
  endtask

  task automatic test_forward();
    do_flush();
    set_instr(5'd5); tick();
    set_instr(5'd7); tick();
    set_instr(5'd5); tick();
    idle();
    wb_valid_i[0] = 1'b1; trans_id_i[0] = 2'd0; wdata_i[0] = 64'hAA;
    tick();
    idle();
    rs1_i = 5'd5;
    #1;
    checks++;
    if (rs1_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL fwd_younger_pending: rs1_valid got %b expected 0", rs1_valid_o);
    end
    wb_valid_i[1] = 1'b1; trans_id_i[1] = 2'd2; wdata_i[1] = 64'hBB;
    tick();
    wb_valid_i = '0;
    checks++;
    if (rs1_valid_o !== 1'b1 || rs1_o !== 64'hBB) begin
      errors++;
      $display("FAIL fwd_youngest: valid=%b data=%h expected valid=1 data=bb", rs1_valid_o, rs1_o);
    end
  endtask

  task automatic test_wb_priority();
    idle();
    wb_valid_i = 3'b111;
    trans_id_i[0] = 2'd1; wdata_i[0] = 64'h11;
    trans_id_i[1] = 2'd3; wdata_i[1] = 64'h33;
    trans_id_i[2] = 2'd1; wdata_i[2] = 64'h22;
    tick();
    idle();
    rs2_i = 5'd7;
    #1;
    checks++;
    if (rs2_valid_o !== 1'b1 || rs2_o !== 64'h22) begin
      errors++;
      $display("FAIL wb_priority: valid=%b data=%h expected valid=1 data=22", rs2_valid_o, rs2_o);
    end
    set_instr(5'd9); tick();
    idle();
    rs1_i = 5'd9;
    #1;
    checks++;
    if (rs1_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL wb_unoccupied: rs1_valid got %b expected 0", rs1_valid_o);
    end
  endtask

  task automatic test_commit_full();
    do_flush();
    dispatch_n(4, 5'd1);
    wb_valid_i[0] = 1'b1; trans_id_i[0] = 2'd0; wdata_i[0] = 64'h55;
    tick();
    idle();
    checks++;
    if (commit_valid_o !== 1'b1 || commit_instr_o.trans_id !== 2'd0 || commit_instr_o.result !== 64'h55) begin
      errors++;
      $display("FAIL commit_head: valid=%b id=%0d res=%h expected 1/0/55",
               commit_valid_o, commit_instr_o.trans_id, commit_instr_o.result);
    end
    commit_ack_i = 1'b1;
    set_instr(5'd8);
    #1;
    checks++;
    if (decoded_instr_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL commit_full_ack: got %b expected 0", decoded_instr_ack_o);
    end
    tick();
    idle();
    checks++;
    if (dut.count_q !== 3'd3 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL commit_full_count: count=%0d full=%b expected 3/0", dut.count_q, full_o);
    end
  endtask

  task automatic test_wrap();
    do_flush();
    dispatch_n(4, 5'd2);
    wb_valid_i = 3'b111;
    for (int k = 0; k < W; k++) begin
      trans_id_i[k] = 2'(k);
      wdata_i[k] = 64'(k + 16);
    end
    tick();
    wb_valid_i = 3'b001; trans_id_i[0] = 2'd3; wdata_i[0] = 64'h13;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (commit_valid_o !== 1'b1 || commit_instr_o.trans_id !== 2'(i)) begin
        errors++;
        $display("FAIL wrap_commit%0d: valid=%b id=%0d expected 1/%0d", i, commit_valid_o, commit_instr_o.trans_id, i);
      end
      commit_ack_i = 1'b1;
      tick();
    end
    idle();
    dispatch_n(2, 5'd4);
    checks++;
    if (dut.tail_q !== 2'd2 || issue_valid_o !== 1'b1 || issue_instr_o.trans_id !== 2'd0) begin
      errors++;
      $display("FAIL wrap_tail: tail=%0d iv=%b id=%0d expected 2/1/0", dut.tail_q, issue_valid_o, issue_instr_o.trans_id);
    end
    issue_ack_i = 1'b1;
    tick();
    issue_ack_i = 1'b0;
    checks++;
    if (issue_valid_o !== 1'b1 || issue_instr_o.trans_id !== 2'd1) begin
      errors++;
      $display("FAIL wrap_issue2: iv=%b id=%0d expected 1/1", issue_valid_o, issue_instr_o.trans_id);
    end
  endtask

  task automatic test_flush();
    wb_valid_i[0] = 1'b1; trans_id_i[0] = 2'd0; wdata_i[0] = 64'h7;
    tick();
    idle();
    flush_i = 1'b1;
    set_instr(5'd6);
    commit_ack_i = 1'b1;
    wb_valid_i[1] = 1'b1; trans_id_i[1] = 2'd1; wdata_i[1] = 64'h9;
    #1;
    checks++;
    if (decoded_instr_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack: got %b expected 0", decoded_instr_ack_o);
    end
    tick();
    idle();
    checks++;
    if (dut.count_q !== 3'd0 || issue_valid_o !== 1'b0 || commit_valid_o !== 1'b0 ||
        rd_busy_o !== 32'h0 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: count=%0d iv=%b cv=%b busy=%h full=%b expected all 0",
               dut.count_q, issue_valid_o, commit_valid_o, rd_busy_o, full_o);
    end
  endtask

  task automatic test_reset_mid();
    dispatch_n(2, 5'd3);
    wb_valid_i[0] = 1'b1; trans_id_i[0] = 2'd0; wdata_i[0] = 64'h1;
    tick();
    idle();
    @(negedge clk_i);
    rst_ni = 1'b0;
    commit_ack_i = 1'b1;
    #1;
    checks++;
    if (commit_valid_o !== 1'b0 || rd_busy_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: cv=%b busy=%h expected 0/0", commit_valid_o, rd_busy_o);
    end
    @(posedge clk_i);
    idle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    q.delete();
    next_id = 0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_random();
    bit          v1, v2;
    logic [63:0] d1, d2;
    int          ui;
    do_flush();
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 1) == 0) set_instr(5'($urandom_range(0, 7)));
      issue_ack_i  = ($urandom_range(0, 1) == 0);
      commit_ack_i = ($urandom_range(0, 1) == 0);
      flush_i      = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < W; k++) begin
        wb_valid_i[k]  = ($urandom_range(0, 2) == 0);
        trans_id_i[k]  = 2'($urandom_range(0, 3));
        wdata_i[k]     = {$urandom, $urandom};
        ex_i[k].valid  = ($urandom_range(0, 7) == 0);
        ex_i[k].cause  = 64'($urandom);
      end
      rs1_i = 5'($urandom_range(0, 7));
      rs2_i = 5'($urandom_range(0, 7));
      #1;
      ui = first_unissued();
      m_fwd(rs1_i, v1, d1);
      m_fwd(rs2_i, v2, d2);
      checks++;
      if (full_o !== (q.size() == N) ||
          decoded_instr_ack_o !== (decoded_instr_valid_i && q.size() < N && !flush_i)) begin
        errors++;
        $display("FAIL rnd_full_ack c=%0d: full=%b ack=%b expected size=%0d", c, full_o, decoded_instr_ack_o, q.size());
      end
      checks++;
      if (issue_valid_o !== (ui >= 0) || (ui >= 0 && issue_instr_o.trans_id !== q[ui].id)) begin
        errors++;
        $display("FAIL rnd_issue c=%0d: iv=%b id=%0d expected iv=%b", c, issue_valid_o, issue_instr_o.trans_id, ui >= 0);
      end
      checks++;
      if (commit_valid_o !== (q.size() > 0 && q[0].done) ||
          (commit_valid_o === 1'b1 && q.size() > 0 &&
           (commit_instr_o.trans_id !== q[0].id || commit_instr_o.result !== q[0].res ||
            commit_instr_o.ex.valid !== q[0].exv))) begin
        errors++;
        $display("FAIL rnd_commit c=%0d: cv=%b id=%0d res=%h exv=%b", c, commit_valid_o,
                 commit_instr_o.trans_id, commit_instr_o.result, commit_instr_o.ex.valid);
      end
      checks++;
      if (rd_busy_o !== m_busy()) begin
        errors++;
        $display("FAIL rnd_busy c=%0d: got %h expected %h", c, rd_busy_o, m_busy());
      end
      checks++;
      if (rs1_valid_o !== v1 || rs2_valid_o !== v2 ||
          (v1 && rs1_o !== d1) || (v2 && rs2_o !== d2)) begin
        errors++;
        $display("FAIL rnd_fwd c=%0d: r1=%b/%h r2=%b/%h expected %b/%h %b/%h",
                 c, rs1_valid_o, rs1_o, rs2_valid_o, rs2_o, v1, d1, v2, d2);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    next_id = 0;
    test_reset();
    test_latency();
    test_full();
    test_forward();
    test_wb_priority();
    test_commit_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 The block SHALL have parameter NR_ENTRIES, default ariane_pkg::NR_SB_ENTRIES (4), meaning the number of in-flight instruction slots, a power of two.
REQ-002 The block SHALL have parameter NR_WB_PORTS, default ariane_pkg::NR_WB_PORTS (3), meaning the number of writeback ports.
REQ-003 The block SHALL have port clk_i, input, width 1, the single clock; the block is rising-edge only.
REQ-004 The block SHALL have port rst_ni, input, width 1, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port flush_i, input, width 1, which discards all entries.
REQ-006 The block SHALL have the following dispatch ports:
- decoded_instr_i, input, scoreboard_entry;
- decoded_instr_valid_i, input, 1;
- decoded_instr_ack_o, output, 1, meaning the instruction was accepted this cycle.
REQ-007 The block SHALL have port full_o, output, 1, asserted when all NR_ENTRIES slots are occupied.
REQ-008 The block SHALL have the following issue ports:
- issue_instr_o, output, scoreboard_entry;
- issue_valid_o, output, 1;
- issue_ack_i, input, 1.
REQ-009 The block SHALL have the following writeback ports:
- trans_id_i, input, NR_WB_PORTS x TRANS_ID_BITS;
- wdata_i, input, NR_WB_PORTS x 64;
- ex_i, input, NR_WB_PORTS x exception;
- wb_valid_i, input, NR_WB_PORTS.
REQ-010 The block SHALL have the following commit ports:
- commit_instr_o, output, scoreboard_entry;
- commit_valid_o, output, 1;
- commit_ack_i, input, 1.
REQ-011 The block SHALL have port rd_busy_o, output, 32, where bit r is set if any occupied entry has rd==r.
REQ-012 The block SHALL have the following forwarding ports:
- rs1_i, input, 5; rs2_i, input, 5;
- rs1_o, output, 64; rs2_o, output, 64;
- rs1_valid_o, output, 1; rs2_valid_o, output, 1.

Function
REQ-013 The block SHALL be a circular buffer with three pointers (commit/head, issue, write/tail) of width TRANS_ID_BITS, plus an occupancy counter of width TRANS_ID_BITS+1; all pointers SHALL wrap modulo NR_ENTRIES.
REQ-014 decoded_instr_ack_o SHALL equal decoded_instr_valid_i && !full_o && !flush_i; full_o SHALL be derived from the registered count only, so a same-cycle commit does not free a slot for dispatch.
REQ-015 On dispatch, the slot at tail SHALL store decoded_instr_i with trans_id forced to the tail index and valid cleared, and tail SHALL advance by 1.
REQ-016 issue_valid_o SHALL be high when issue pointer != tail or count==NR_ENTRIES with issue==head and the head entry not yet issued; issue_instr_o SHALL show the slot at the issue pointer.
REQ-017 issue_ack_i while issue_valid_o is high SHALL advance the issue pointer; issue_ack_i while issue_valid_o is low SHALL be ignored.
REQ-018 A dispatched entry SHALL become issuable on the following cycle (1-cycle latency).
REQ-019 A writeback on port k with wb_valid_i[k] targeting an occupied slot SHALL set result=wdata_i[k] and valid=1, and SHALL set ex=ex_i[k] if ex_i[k].valid.
REQ-020 A writeback to an unoccupied slot SHALL be ignored.
REQ-021 If several writeback ports target the same slot in one cycle, the highest port index SHALL win.
REQ-022 commit_valid_o SHALL equal (count>0) && the registered head entry's valid flag; commit_instr_o SHALL show the head slot.
REQ-023 A writeback and a commit landing on the head in the same cycle SHALL become visible to commit on the next cycle.
REQ-024 commit_ack_i with commit_valid_o high SHALL advance head and clear that slot's occupancy; commit_ack_i with commit_valid_o low SHALL be ignored.
REQ-025 The issue pointer SHALL never lag head.
REQ-026 Simultaneous dispatch and commit SHALL leave count unchanged.
REQ-027 rd_busy_o[0] SHALL always be 0.
REQ-028 Forwarding SHALL search occupied slots for rd==rsX_i with valid=1, taking the youngest such slot (nearest to tail); rsX_valid_o SHALL be 1 and rsX_o SHALL carry its result.
REQ-029 rsX_valid_o SHALL be 0 when a younger matching slot exists that is not yet valid, and also when rsX_i==0.
REQ-030 flush_i SHALL take priority over dispatch, issue, writeback and commit: next cycle all pointers=0, count=0, all occupancy and valid flags cleared.

Reset
REQ-031 While rst_ni is low the block SHALL hold pointers=0, count=0, all slot occupancy/valid flags=0, full_o=0, issue_valid_o=0, commit_valid_o=0, rd_busy_o=0, rs1_valid_o=rs2_valid_o=0, and decoded_instr_ack_o=0.
REQ-032 Slot payload SHALL need no reset.
REQ-033 Reset asserted mid-operation SHALL discard all entries without emitting a commit.

Structure
REQ-034 scoreboard_entry, exception, NR_SB_ENTRIES, TRANS_ID_BITS and NR_WB_PORTS SHALL come from ariane_pkg; no new package types are needed.
REQ-035 The block SHALL be a single module with no sub-module; the forwarding search SHALL be a combinational loop ordered from head to tail.

Verification
REQ-036 The bench SHALL dispatch 4 instructions with no commits; it SHALL then observe full_o=1, and a 5th valid SHALL see ack=0 and the tail pointer unchanged.
REQ-037 With entries with rd=5 at trans_id 0 and rd=5 at trans_id 2, the bench SHALL write back id 0 with 0xAA; rs1_i=5 SHALL then give rs1_valid_o=0. After writing back id 2 with 0xBB, rs1_i=5 SHALL give rs1_o=0xBB and rs1_valid_o=1.
REQ-038 The bench SHALL drive ports 0 and 2 both writing id 1 (0x11, 0x22) in the same cycle; the slot result SHALL be 0x22.
REQ-039 When full, the bench SHALL apply commit_ack_i and decoded_instr_valid_i together; dispatch SHALL be rejected and count SHALL become 3.
REQ-040 The bench SHALL dispatch 4, commit 4 and dispatch 2; the pointers SHALL wrap (tail=2) and trans_ids SHALL be 0 and 1.
REQ-041 The bench SHALL apply flush_i in the same cycle as dispatch, writeback and commit_ack; the next cycle SHALL show count=0, all valids=0 and rd_busy_o=0.
